data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//  Data-side memory of the RV32I core (Harvard: instruction memory is separate).
//  Consumes the core's mem_data_r_*/mem_data_w_* requests and returns read data.
//  Performs little-endian byte/half/word lane handling and alignment/range checking.
//  Reports status on mem_data_state; the core samples it at writeback.
//  Captures the first faulting address for debug.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words; must be a power of two
//  BASE_ADDR    32'h00000000  byte address of word 0
//  MMIO_ADDR    32'hFFFFFF00  word address of the MMIO output register (DMEM_MMIO_EN only)
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst_n        in   1   synchronous reset, active-low
//  r_en         in   1   read request
//  r_addr       in   32  byte address
//  r_mode       in   2   00 byte, 01 half, 10 word, 11 illegal
//  r_data       out  32  read data, right-justified, zero-extended
//  w_en         in   1   write request
//  w_addr       in   32  byte address
//  w_data       in   32  write data, right-justified
//  w_mode       in   2   encoded as r_mode
//  state        out  2   00 OK, 01 MISALIGNED, 10 OUT_OF_RANGE, 11 CONFLICT
//  err_valid    out  1   sticky: a fault has been captured
//  err_addr     out  32  address of the first fault
//  mmio_out     out  32  MMIO register (DMEM_MMIO_EN only)
// BEHAVIOUR
//  Reset (rst_n low at posedge):
//   - r_data=0, state=00, err_valid=0, err_addr=0, mmio_out=0.
//   - Array contents are not cleared.
//  Access checks:
//   - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or mode 11.
//   - Range: off = addr-BASE_ADDR (32-bit wrap); in range iff off < DEPTH_WORDS*4.
//   - Priority: CONFLICT > MISALIGNED > OUT_OF_RANGE > OK.
//  Each posedge, rst_n high, one case applies:
//   - r_en & w_en: state<=11, no write, r_data<=0.
//   - r_en only: if OK, r_data <= lane extract of word off[..:2].
//     byte -> lane off[1:0], bits 7:0; half -> lane off[1], bits 15:0; upper bits 0.
//     If faulted: r_data<=0 and state<=code.
//   - w_en only: if OK, write with byte mask.
//     byte -> mask 1<<off[1:0], data w_data[7:0] replicated.
//     half -> mask 0011/1100, data w_data[15:0] replicated; word -> 1111.
//     If faulted: no write, state<=code.
//   - neither: state<=00; r_data holds its value.
//  Latency and handshake:
//   - Read latency is 1 clock; r_data is re-evaluated every clock while r_en is high.
//   - No ready/valid: the request must be held for >=1 clock before it is sampled.
//     The core's EXECUTE->MEMORY->WB sequence guarantees 2.
//   - Writes repeat each clock while w_en is high (idempotent).
//  Fault capture: first fault with err_valid=0 sets err_valid=1 and err_addr to the faulting
//   address (r_addr for CONFLICT). Held until reset; later faults are ignored.
//  Reset mid-access: the pending write is discarded, outputs return to reset values.
// CONFIGURATION
//  DMEM_MMIO_EN defined:
//   - A word write with w_addr==MMIO_ADDR updates mmio_out and not the array.
//     The range check is bypassed for it.
//   - Byte/half writes there return OUT_OF_RANGE.
//   - Word read of MMIO_ADDR returns mmio_out.
//  DMEM_MMIO_EN undefined: mmio_out port absent; MMIO_ADDR is an ordinary out-of-range address.
// TESTING
//  - Word write 0xDEADBEEF @0x10, then byte reads @0x10..0x13 -> 0xEF,0xBE,0xAD,0xDE; state 00.
//  - Half write 0x1234 @0x22 over 0xDEADBEEF @0x20, word read @0x20 -> 0x1234BEEF.
//  - Word read @0x06 -> state 01, r_data 0, err_valid 1, err_addr 0x06.
//    Then word read @0x4000 -> state 10, err_addr stays 0x06.
//  - r_en & w_en together @0x8 -> state 11; later read @0x8 shows the previous contents.
//  - Reset mid-write (w_en high, rst_n low same edge) -> target word unchanged; state 00, err_valid 0.
//  - DMEM_MMIO_EN: word write 0xA5 @0xFFFFFF00 -> mmio_out 0xA5; read -> 0xA5.
//    Byte write there -> state 10.

Source files
------------

// File: rtl/data_mem.sv
// rtl/data_mem.sv - RV32I data memory with lane handling, access checks and fault capture
// Optional build macro DMEM_MMIO_EN: adds the mmio_out word register at MMIO_ADDR.
module data_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r_en,
    input  logic [31:0] r_addr,
    input  logic [1:0]  r_mode,
    output logic [31:0] r_data,
    input  logic        w_en,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_data,
    input  logic [1:0]  w_mode,
    output logic [1:0]  state,
    output logic        err_valid,
    output logic [31:0] err_addr
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_MIS  = 2'b01;
    localparam logic [1:0] ST_OOR  = 2'b10;
    localparam logic [1:0] ST_CONF = 2'b11;

    localparam logic [1:0] M_BYTE = 2'b00;
    localparam logic [1:0] M_HALF = 2'b01;
    localparam logic [1:0] M_WORD = 2'b10;

    logic [31:0] mem [DEPTH_WORDS];

    // Misalignment outranks range; the MMIO word is reachable only as a whole word.
    function automatic logic [1:0] access_code(input logic [31:0] addr,
                                               input logic [31:0] off,
                                               input logic [1:0]  mode);
        logic mis;
        mis = (mode == 2'b11) ||
              (mode == M_HALF && addr[0]) ||
              (mode == M_WORD && addr[1:0] != 2'b00);
        if (mis) begin
            return ST_MIS;
        end
`ifdef DMEM_MMIO_EN
        if (addr == MMIO_ADDR) begin
            return (mode == M_WORD) ? ST_OK : ST_OOR;
        end
`endif
        if ({1'b0, off} >= SPAN) begin
            return ST_OOR;
        end
        return ST_OK;
    endfunction

    logic [31:0]   r_off, w_off, r_word, rd_val, wr_word, next_rdata, fault_addr;
    logic [AW-1:0] r_idx, w_idx;
    logic [1:0]    r_code, w_code, next_state;
    logic [3:0]    wr_mask;
    logic          wr_fire, fault;
`ifdef DMEM_MMIO_EN
    logic [31:0]   mmio_q;
    logic          mmio_wr;
`endif

    // Decode both ports, pick the single case that applies this cycle.
    always_comb begin
        r_off   = r_addr - BASE_ADDR;
        w_off   = w_addr - BASE_ADDR;
        r_idx   = r_off[AW+1:2];
        w_idx   = w_off[AW+1:2];
        r_code  = access_code(r_addr, r_off, r_mode);
        w_code  = access_code(w_addr, w_off, w_mode);
        r_word  = mem[r_idx];
`ifdef DMEM_MMIO_EN
        mmio_wr = 1'b0;
        if (r_addr == MMIO_ADDR) begin
            r_word = mmio_q;
        end
`endif
        case (r_mode)
            M_BYTE:  rd_val = {24'h0, r_word[{r_off[1:0], 3'b000} +: 8]};
            M_HALF:  rd_val = {16'h0, (r_off[1] ? r_word[31:16] : r_word[15:0])};
            default: rd_val = r_word;
        endcase
        case (w_mode)
            M_BYTE: begin
                wr_mask = 4'b0001 << w_off[1:0];
                wr_word = {4{w_data[7:0]}};
            end
            M_HALF: begin
                wr_mask = w_off[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{w_data[15:0]}};
            end
            default: begin
                wr_mask = 4'b1111;
                wr_word = w_data;
            end
        endcase

        next_state = ST_OK;
        next_rdata = r_data;
        fault      = 1'b0;
        fault_addr = r_addr;
        wr_fire    = 1'b0;
        if (r_en && w_en) begin
            next_state = ST_CONF;
            next_rdata = 32'h0;
            fault      = 1'b1;
        end else if (r_en) begin
            next_state = r_code;
            next_rdata = (r_code == ST_OK) ? rd_val : 32'h0;
            fault      = (r_code != ST_OK);
        end else if (w_en) begin
            next_state = w_code;
            fault      = (w_code != ST_OK);
            fault_addr = w_addr;
`ifdef DMEM_MMIO_EN
            if (w_code == ST_OK && w_addr == MMIO_ADDR) begin
                mmio_wr = 1'b1;
            end else begin
                wr_fire = (w_code == ST_OK);
            end
`else
            wr_fire = (w_code == ST_OK);
`endif
        end
    end

    // Status, read data and sticky first-fault capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data    <= 32'h0;
            state     <= ST_OK;
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
        end else begin
            r_data <= next_rdata;
            state  <= next_state;
            if (fault && !err_valid) begin
                err_valid <= 1'b1;
                err_addr  <= fault_addr;
            end
        end
    end

    // Byte-masked array write; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[w_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_MMIO_EN
    // Memory-mapped output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mmio_q <= 32'h0;
        end else if (mmio_wr) begin
            mmio_q <= w_data;
        end
    end

    assign mmio_out = mmio_q;
`endif

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard bench for data_mem
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_en = 1'b0, w_en = 1'b0;
    logic [31:0] r_addr = '0, w_addr = '0, w_data = '0;
    logic [1:0]  r_mode = '0, w_mode = '0;
    logic [31:0] r_data, err_addr;
    logic [1:0]  state;
    logic        err_valid;
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_out;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  mode;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  st;
    } op_t;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  st;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hold = 32'h0;

    data_mem dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r_en     (r_en),
        .r_addr   (r_addr),
        .r_mode   (r_mode),
        .r_data   (r_data),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_mode   (w_mode),
        .state    (state),
        .err_valid(err_valid),
        .err_addr (err_addr)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_out (mmio_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic op_t mk(input logic re, input logic we, input logic [31:0] addr,
                               input logic [1:0] mode, input logic [31:0] wd,
                               input logic [31:0] rd, input logic [1:0] st);
        op_t o;
        o.re = re; o.we = we; o.addr = addr; o.mode = mode; o.wd = wd; o.rd = rd; o.st = st;
        return o;
    endfunction

    task automatic push_exp(input op_t o);
        exp_t e;
        if (o.re) hold = o.rd;
        e.rd = hold;
        e.st = o.st;
        sb.push_back(e);
    endtask

    task automatic drive(input op_t o);
        @(negedge clk);
        r_en = o.re; w_en = o.we;
        r_addr = o.addr; w_addr = o.addr;
        r_mode = o.mode; w_mode = o.mode;
        w_data = o.wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        r_en = 1'b0;
        w_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (r_data !== 32'h0 || state !== 2'b00 || err_valid !== 1'b0 || err_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset r_data=%h state=%b err_valid=%b err_addr=%h expected all zero",
                     r_data, state, err_valid, err_addr);
        end
`ifdef DMEM_MMIO_EN
        checks++;
        if (mmio_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_mmio mmio_out=%h expected 0", mmio_out);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        hold = 32'h0;
    endtask

    task automatic test_faults();
        op_t  ops[$];
        exp_t e;
        ops.push_back(mk(1, 0, 32'h0000_0006, W, 0, 32'h0, 2'b01));
        ops.push_back(mk(1, 0, 32'h0000_4000, W, 0, 32'h0, 2'b10));
        ops.push_back(mk(0, 1, 32'h0000_0000, W, 32'h5A5A_5A5A, 0, 2'b00));
        ops.push_back(mk(0, 1, 32'h0000_1000, W, 32'hFFFF_FFFF, 0, 2'b10));
        ops.push_back(mk(1, 0, 32'h0000_0000, W, 0, 32'h5A5A_5A5A, 2'b00));
        ops.push_back(mk(0, 1, 32'h0000_0FFC, W, 32'h0BAD_CAFE, 0, 2'b00));
        ops.push_back(mk(1, 0, 32'h0000_0FFC, W, 0, 32'h0BAD_CAFE, 2'b00));
        ops.push_back(mk(1, 0, 32'h0000_0FFE, H, 0, 32'h0000_0BAD, 2'b00));
        ops.push_back(mk(0, 0, 32'h0000_0000, W, 0, 0, 2'b00));
        ops.push_back(mk(1, 0, 32'h0000_0000, X, 0, 32'h0, 2'b01));
        ops.push_back(mk(0, 1, 32'h0000_0001, H, 32'h1111_1111, 0, 2'b01));
        ops.push_back(mk(1, 0, 32'hFFFF_FFFF, B, 0, 32'h0, 2'b10));
        ops.push_back(mk(1, 0, 32'h0000_4002, W, 0, 32'h0, 2'b01));
        ops.push_back(mk(1, 0, 32'h0000_0000, W, 0, 32'h5A5A_5A5A, 2'b00));
        foreach (ops[i]) begin
            push_exp(ops[i]);
            drive(ops[i]);
            e = sb.pop_front();
            checks++;
            if (r_data !== e.rd || state !== e.st) begin
                failures++;
                $display("FAIL faults[%0d] r_data=%h state=%b expected r_data=%h state=%b",
                         i, r_data, state, e.rd, e.st);
            end
        end
        idle();
        checks++;
        if (err_valid !== 1'b1 || err_addr !== 32'h0000_0006) begin
            failures++;
            $display("FAIL fault_capture err_valid=%b err_addr=%h expected 1 00000006",
                     err_valid, err_addr);
        end
    endtask

    task automatic test_byte_lanes();
        op_t  ops[$];
        exp_t e;
        ops.push_back(mk(0, 1, 32'h10, W, 32'hDEAD_BEEF, 0, 2'b00));
        ops.push_back(mk(1, 0, 32'h10, B, 0, 32'h0000_00EF, 2'b00));
        ops.push_back(mk(1, 0, 32'h11, B, 0, 32'h0000_00BE, 2'b00));
        ops.push_back(mk(1, 0, 32'h12, B, 0, 32'h0000_00AD, 2'b00));
        ops.push_back(mk(1, 0, 32'h13, B, 0, 32'h0000_00DE, 2'b00));
        ops.push_back(mk(1, 0, 32'h12, H, 0, 32'h0000_DEAD, 2'b00));
        foreach (ops[i]) begin
            push_exp(ops[i]);
            drive(ops[i]);
            e = sb.pop_front();
            checks++;
            if (r_data !== e.rd || state !== e.st) begin
                failures++;
                $display("FAIL lanes[%0d] r_data=%h state=%b expected r_data=%h state=%b",
                         i, r_data, state, e.rd, e.st);
            end
        end
        idle();
    endtask

    task automatic test_half_merge();
        op_t  ops[$];
        exp_t e;
        ops.push_back(mk(0, 1, 32'h20, W, 32'hDEAD_BEEF, 0, 2'b00));
        ops.push_back(mk(0, 1, 32'h22, H, 32'hFFFF_1234, 0, 2'b00));
        ops.push_back(mk(1, 0, 32'h20, W, 0, 32'h1234_BEEF, 2'b00));
        ops.push_back(mk(1, 0, 32'h20, H, 0, 32'h0000_BEEF, 2'b00));
        ops.push_back(mk(0, 1, 32'h21, B, 32'hAAAA_AA77, 0, 2'b00));
        ops.push_back(mk(1, 0, 32'h20, W, 0, 32'h1234_77EF, 2'b00));
        foreach (ops[i]) begin
            push_exp(ops[i]);
            drive(ops[i]);
            e = sb.pop_front();
            checks++;
            if (r_data !== e.rd || state !== e.st) begin
                failures++;
                $display("FAIL half[%0d] r_data=%h state=%b expected r_data=%h state=%b",
                         i, r_data, state, e.rd, e.st);
            end
        end
        idle();
    endtask

    task automatic test_conflict();
        op_t  ops[$];
        exp_t e;
        ops.push_back(mk(0, 1, 32'h8, W, 32'h1122_3344, 0, 2'b00));
        ops.push_back(mk(1, 0, 32'h8, W, 0, 32'h1122_3344, 2'b00));
        ops.push_back(mk(1, 1, 32'h8, W, 32'hFFFF_FFFF, 32'h0, 2'b11));
        ops.push_back(mk(1, 0, 32'h8, W, 0, 32'h1122_3344, 2'b00));
        foreach (ops[i]) begin
            push_exp(ops[i]);
            drive(ops[i]);
            e = sb.pop_front();
            checks++;
            if (r_data !== e.rd || state !== e.st) begin
                failures++;
                $display("FAIL conflict[%0d] r_data=%h state=%b expected r_data=%h state=%b",
                         i, r_data, state, e.rd, e.st);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        op_t         ops[$];
        exp_t        e;
        logic [31:0] vals[8];
        logic [31:0] v0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = $urandom;
            ops.push_back(mk(0, 1, 32'h100 + 32'(4 * i), W, vals[i], 0, 2'b00));
        end
        for (int i = 7; i >= 0; i--) begin
            ops.push_back(mk(1, 0, 32'h100 + 32'(4 * i), W, 0, vals[i], 2'b00));
        end
        v0 = vals[0];
        for (int k = 0; k < 4; k++) begin
            ops.push_back(mk(1, 0, 32'h100 + 32'(k), B, 0, {24'h0, v0[8*k +: 8]}, 2'b00));
        end
        foreach (ops[i]) begin
            push_exp(ops[i]);
            drive(ops[i]);
            e = sb.pop_front();
            checks++;
            if (r_data !== e.rd || state !== e.st) begin
                failures++;
                $display("FAIL b2b[%0d] r_data=%h state=%b expected r_data=%h state=%b",
                         i, r_data, state, e.rd, e.st);
            end
        end
        idle();
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        op_t  ops[$];
        exp_t e;
        ops.push_back(mk(0, 1, 32'hFFFF_FF00, W, 32'h0000_00A5, 0, 2'b00));
        ops.push_back(mk(1, 0, 32'hFFFF_FF00, W, 0, 32'h0000_00A5, 2'b00));
        ops.push_back(mk(0, 1, 32'hFFFF_FF00, B, 32'h0000_0011, 0, 2'b10));
        ops.push_back(mk(0, 1, 32'hFFFF_FF00, H, 32'h0000_2222, 0, 2'b10));
        ops.push_back(mk(1, 0, 32'hFFFF_FF00, B, 0, 32'h0, 2'b10));
        foreach (ops[i]) begin
            push_exp(ops[i]);
            drive(ops[i]);
            e = sb.pop_front();
            checks++;
            if (r_data !== e.rd || state !== e.st) begin
                failures++;
                $display("FAIL mmio[%0d] r_data=%h state=%b expected r_data=%h state=%b",
                         i, r_data, state, e.rd, e.st);
            end
        end
        idle();
        checks++;
        if (mmio_out !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL mmio_out value=%h expected 000000a5", mmio_out);
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        op_t  ops[$];
        exp_t e;
        drive(mk(0, 1, 32'h30, W, 32'hCAFE_F00D, 0, 2'b00));
        drive(mk(1, 0, 32'h30, W, 0, 0, 2'b00));
        @(negedge clk);
        r_en = 1'b0; w_en = 1'b1;
        w_addr = 32'h30; w_mode = W; w_data = 32'h0000_0000;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (r_data !== 32'h0 || state !== 2'b00 || err_valid !== 1'b0 || err_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid r_data=%h state=%b err_valid=%b err_addr=%h expected all zero",
                     r_data, state, err_valid, err_addr);
        end
        @(negedge clk);
        w_en = 1'b0;
        rst_n = 1'b1;
        hold = 32'h0;
        ops.push_back(mk(1, 0, 32'h30, W, 0, 32'hCAFE_F00D, 2'b00));
        ops.push_back(mk(1, 0, 32'h8, W, 0, 32'h1122_3344, 2'b00));
        foreach (ops[i]) begin
            push_exp(ops[i]);
            drive(ops[i]);
            e = sb.pop_front();
            checks++;
            if (r_data !== e.rd || state !== e.st) begin
                failures++;
                $display("FAIL reset_keep[%0d] r_data=%h state=%b expected r_data=%h state=%b",
                         i, r_data, state, e.rd, e.st);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_faults();
        test_byte_lanes();
        test_half_merge();
        test_conflict();
        test_back_to_back();
`ifdef DMEM_MMIO_EN
        test_mmio();
`endif
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
